uart_avm_responder: RTL and testbench

Avalon-MM slave that models the RS232 UART peripheral polled by the RSA wrapper: RX data at byte address 0, TX data at 4, status at 8. Host-side bytes enter on a valid/ready byte stream into an RX FIFO. Bytes written by the master leave through a single-entry TX holding register on a second byte stream. A programmable waitrequest stretch exercises the master's polling FSM in simulation and on FPGA.

---
 rtl/uart_avm_pkg.sv | 19 +
 rtl/uart_avm_responder_byte_fifo.sv | 47 ++++
 rtl/uart_avm_responder.sv | 142 ++++++++++++++
 tb/tb_uart_avm_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_avm_pkg.sv
// Shared register map, status bit positions and access FSM states for the
// UART Avalon-MM responder.
package uart_avm_pkg;

  localparam logic [4:0] RX_ADDR     = 5'h00;
  localparam logic [4:0] TX_ADDR     = 5'h04;
  localparam logic [4:0] STATUS_ADDR = 5'h08;

  localparam int RX_OK_BIT   = 7;
  localparam int TX_OK_BIT   = 6;
  localparam int TX_DROP_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

endpackage

// File: rtl/uart_avm_responder_byte_fifo.sv
// Synchronous 8-bit FIFO with wrap-bit pointers; head shows the oldest entry.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic [7:0]  r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_head    = r_mem[r_rp[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so a flush only needs the pointers cleared.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_avm_responder.sv
// Avalon-MM model of the polled RS232 UART: RX FIFO, single-entry TX holding
// register, sticky TX_DROP, and a programmable waitrequest stretch.
module uart_avm_responder
  import uart_avm_pkg::*;
#(
  parameter int RX_DEPTH    = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic [31:0] avm_readdata,
  output logic        avm_waitrequest,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_addr;
  logic        r_rd;
  logic        r_wr;
  logic [7:0]  r_wdata;
  logic        r_rx_hit;
  logic [31:0] r_readdata;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_tx_drop;

  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_head;
  logic        w_req;
  logic        w_go_ack;
  logic        w_ack;
  logic        w_tx_load;
  logic [31:0] w_rd_value;

  assign w_req    = avm_read || avm_write;
  assign w_go_ack = ((r_state == S_IDLE) && w_req && (WAIT_CYCLES == 0)) ||
                    ((r_state == S_WAIT) && w_req && (r_cnt == 4'd0));
  assign w_ack    = (r_state == S_ACK);

  assign avm_waitrequest = !w_ack;
  assign avm_readdata    = r_readdata;
  assign rx_ready        = !w_full;
  assign tx_data         = r_tx_data;
  assign tx_valid        = r_tx_valid;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk   (avm_clk),
    .i_rst   (avm_rst),
    .i_push  (rx_valid && !w_full),
    .i_data  (rx_data),
    .i_pop   (w_ack && r_rx_hit),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_comb begin
    w_rd_value = '0;
    case (avm_address)
      RX_ADDR:     if (!w_empty) w_rd_value[7:0] = w_head;
      STATUS_ADDR: begin
        w_rd_value[RX_OK_BIT]   = !w_empty;
        w_rd_value[TX_OK_BIT]   = !r_tx_valid;
        w_rd_value[TX_DROP_BIT] = r_tx_drop;
      end
      default:     w_rd_value = '0;
    endcase
  end

  // Access FSM plus the snapshot of the request taken on entry to S_ACK.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_rx_hit   <= 1'b0;
      r_readdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_state <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
          r_cnt   <= 4'(WAIT_CYCLES - 1);
        end
        S_WAIT: begin
          if (!w_req)               r_state <= S_IDLE;
          else if (r_cnt == 4'd0)   r_state <= S_ACK;
          else                      r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_go_ack) begin
        r_addr   <= avm_address;
        r_rd     <= avm_read;
        r_wr     <= avm_write && !avm_read;
        r_wdata  <= avm_writedata[7:0];
        // Pop only a byte that was actually returned, even if one arrives later.
        r_rx_hit <= avm_read && (avm_address == RX_ADDR) && !w_empty;
        if (avm_read) r_readdata <= w_rd_value;
      end
    end
  end

  assign w_tx_load = w_ack && r_wr && (r_addr == TX_ADDR);

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_drop  <= 1'b0;
    end else begin
      if (w_tx_load) begin
        // A same-cycle handoff frees the register, so the new byte fits.
        if (r_tx_valid && !tx_ready) begin
          r_tx_drop <= 1'b1;
        end else begin
          r_tx_data  <= r_wdata;
          r_tx_valid <= 1'b1;
        end
      end else if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
      end

      if (w_ack && r_rd && (r_addr == STATUS_ADDR)) r_tx_drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_avm_responder.sv
// Directed bench for uart_avm_responder with a readdata scoreboard queue.
module tb_uart_avm_responder;

  localparam int RX_DEPTH    = 4;
  localparam int WAIT_CYCLES = 1;

  logic        avm_clk = 1'b0;
  logic        avm_rst = 1'b1;
  logic [4:0]  avm_address = '0;
  logic        avm_read = 1'b0;
  logic        avm_write = 1'b0;
  logic [31:0] avm_writedata = '0;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  always #5 avm_clk = ~avm_clk;

  uart_avm_responder #(.RX_DEPTH(RX_DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .avm_clk         (avm_clk),
    .avm_rst         (avm_rst),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One Avalon access; reads are compared against the scoreboard on ack.
  task automatic access(input string tag, input logic [4:0] addr, input bit rd,
                        input bit wr, input logic [7:0] wdata,
                        input logic [31:0] exp, output int lat);
    bit got;
    logic [31:0] want;
    if (rd) exp_q.push_back(exp);
    @(negedge avm_clk);
    avm_address   = addr;
    avm_read      = rd;
    avm_write     = wr;
    avm_writedata = {24'hDEAD_BE, wdata};
    lat = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge avm_clk);
      lat++;
      if (!avm_waitrequest) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=waitrequest_stuck expected=ack", tag);
      if (rd) void'(exp_q.pop_front());
    end else if (rd) begin
      want = exp_q.pop_front();
      check(tag, avm_readdata, want);
    end
    avm_read  = 1'b0;
    avm_write = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge avm_clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge avm_clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    int lat;

    repeat (3) @(negedge avm_clk);
    check("rst_waitreq", 32'(avm_waitrequest), 32'd1);
    check("rst_readdata", avm_readdata, 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    avm_rst = 1'b0;

    // First status read and its latency.
    access("status_idle", 5'h08, 1, 0, 8'h00, 32'h40, lat);
    check("latency", 32'(lat), 32'(WAIT_CYCLES + 1));

    // Two bytes in, read back in order.
    push_byte(8'hA5);
    push_byte(8'h3C);
    access("status_rx", 5'h08, 1, 0, 8'h00, 32'hC0, lat);
    access("rx_a5", 5'h00, 1, 0, 8'h00, 32'hA5, lat);
    access("rx_3c", 5'h00, 1, 0, 8'h00, 32'h3C, lat);
    access("status_drained", 5'h08, 1, 0, 8'h00, 32'h40, lat);

    // Fill the FIFO, then hold a fifth byte against back-pressure.
    for (int i = 1; i <= 4; i++) begin
      check("fill_ready", 32'(rx_ready), 32'd1);
      push_byte(8'(i));
    end
    check("full_ready_low", 32'(rx_ready), 32'd0);
    @(negedge avm_clk);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (3) @(negedge avm_clk);
    check("full_hold", 32'(rx_ready), 32'd0);
    access("rx_01", 5'h00, 1, 0, 8'h00, 32'h01, lat);
    @(negedge avm_clk);
    check("ready_after_pop", 32'(rx_ready), 32'd1);
    @(negedge avm_clk);
    rx_valid = 1'b0;
    check("refull_ready_low", 32'(rx_ready), 32'd0);
    access("rx_02", 5'h00, 1, 0, 8'h00, 32'h02, lat);
    access("rx_03", 5'h00, 1, 0, 8'h00, 32'h03, lat);
    access("rx_04", 5'h00, 1, 0, 8'h00, 32'h04, lat);
    access("rx_55", 5'h00, 1, 0, 8'h00, 32'h55, lat);

    // TX holding register, drop and sticky flag clear.
    tx_ready = 1'b0;
    access("tx_w11", 5'h04, 0, 1, 8'h11, 32'h0, lat);
    @(negedge avm_clk);
    check("tx_valid_set", 32'(tx_valid), 32'd1);
    check("tx_data_11", 32'(tx_data), 32'h11);
    access("tx_w22", 5'h04, 0, 1, 8'h22, 32'h0, lat);
    access("status_drop", 5'h08, 1, 0, 8'h00, 32'h01, lat);
    access("status_drop_clr", 5'h08, 1, 0, 8'h00, 32'h00, lat);
    check("tx_data_kept", 32'(tx_data), 32'h11);
    access("tx_read_zero", 5'h04, 1, 0, 8'h00, 32'h0, lat);
    @(negedge avm_clk);
    tx_ready = 1'b1;
    @(negedge avm_clk);
    check("tx_valid_fall", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    access("status_tx_free", 5'h08, 1, 0, 8'h00, 32'h40, lat);

    // Empty read, unmapped read and write, read+write treated as read.
    access("rx_empty", 5'h00, 1, 0, 8'h00, 32'h00, lat);
    access("unmapped_rd", 5'h14, 1, 0, 8'h00, 32'h00, lat);
    access("unmapped_wr", 5'h10, 0, 1, 8'h99, 32'h0, lat);
    access("rdwr_tx", 5'h04, 1, 1, 8'h77, 32'h00, lat);
    @(negedge avm_clk);
    check("rdwr_no_load", 32'(tx_valid), 32'd0);
    access("status_clean", 5'h08, 1, 0, 8'h00, 32'h40, lat);

    // Reset in the middle of a stretched access with bytes queued.
    push_byte(8'h77);
    push_byte(8'h88);
    @(negedge avm_clk);
    avm_address = 5'h00;
    avm_read    = 1'b1;
    @(negedge avm_clk);
    avm_rst  = 1'b1;
    avm_read = 1'b0;
    #1;
    check("midrst_waitreq", 32'(avm_waitrequest), 32'd1);
    check("midrst_readdata", avm_readdata, 32'h0);
    check("midrst_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge avm_clk);
    avm_rst = 1'b0;
    access("status_after_rst", 5'h08, 1, 0, 8'h00, 32'h40, lat);
    access("rx_after_rst", 5'h00, 1, 0, 8'h00, 32'h00, lat);

    repeat (2) @(negedge avm_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
